// File: rtl/vga_timing_gen.sv
// Programmable VGA timing generator and pixel output stage in the clk_v domain.
// Optional colour-bar self test is built only when VGA_TIMING_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
  parameter int CNT_WIDTH   = 12,
  parameter int COLOR_WIDTH = 4
) (
  input  logic                     clk_v,
  input  logic                     rst_v,
  input  logic                     enable_i,
  input  logic                     cfg_valid_i,
  input  logic [CNT_WIDTH-1:0]     hsync_end_i,
  input  logic [CNT_WIDTH-1:0]     hpulse_end_i,
  input  logic [CNT_WIDTH-1:0]     hdata_begin_i,
  input  logic [CNT_WIDTH-1:0]     hdata_end_i,
  input  logic [CNT_WIDTH-1:0]     vsync_end_i,
  input  logic [CNT_WIDTH-1:0]     vpulse_end_i,
  input  logic [CNT_WIDTH-1:0]     vdata_begin_i,
  input  logic [CNT_WIDTH-1:0]     vdata_end_i,
  input  logic                     hsync_pol_i,
  input  logic                     vsync_pol_i,
  input  logic                     self_test_i,
  input  logic [3*COLOR_WIDTH-1:0] data_i,
  output logic                     data_req_o,
  output logic [COLOR_WIDTH-1:0]   red_o,
  output logic [COLOR_WIDTH-1:0]   green_o,
  output logic [COLOR_WIDTH-1:0]   blue_o,
  output logic                     hsync_o,
  output logic                     vsync_o,
  output logic                     blank_o,
  output logic                     frame_start_o,
  output logic                     line_start_o,
  output logic                     cfg_err_o,
  output logic [CNT_WIDTH-1:0]     hcnt_o,
  output logic [CNT_WIDTH-1:0]     vcnt_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [CNT_WIDTH-1:0] h_total;
    logic [CNT_WIDTH-1:0] h_pulse;
    logic [CNT_WIDTH-1:0] h_dbeg;
    logic [CNT_WIDTH-1:0] h_dend;
    logic [CNT_WIDTH-1:0] v_total;
    logic [CNT_WIDTH-1:0] v_pulse;
    logic [CNT_WIDTH-1:0] v_dbeg;
    logic [CNT_WIDTH-1:0] v_dend;
    logic                 h_pol;
    logic                 v_pol;
  } cfg_t;

  function automatic logic cfg_ok(input cfg_t c);
    return (c.h_pulse < c.h_dbeg) && (c.h_dbeg < c.h_dend) && (c.h_dend <= c.h_total) &&
           (c.v_pulse < c.v_dbeg) && (c.v_dbeg < c.v_dend) && (c.v_dend <= c.v_total);
  endfunction

  function automatic cfg_t cfg_default();
    cfg_t c;
    c.h_total = CNT_WIDTH'(800);
    c.h_pulse = CNT_WIDTH'(96);
    c.h_dbeg  = CNT_WIDTH'(144);
    c.h_dend  = CNT_WIDTH'(784);
    c.v_total = CNT_WIDTH'(525);
    c.v_pulse = CNT_WIDTH'(2);
    c.v_dbeg  = CNT_WIDTH'(35);
    c.v_dend  = CNT_WIDTH'(515);
    c.h_pol   = 1'b0;
    c.v_pol   = 1'b0;
    return c;
  endfunction

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   hcnt_q, hcnt_d;
  logic [CNT_WIDTH-1:0]   vcnt_q, vcnt_d;
  cfg_t                   cur_q, cur_d;
  cfg_t                   pend_q, pend_d;
  logic                   pend_vld_q, pend_vld_d;
  logic [COLOR_WIDTH-1:0] red_q, red_d;
  logic [COLOR_WIDTH-1:0] green_q, green_d;
  logic [COLOR_WIDTH-1:0] blue_q, blue_d;
  logic                   hsync_q, hsync_d;
  logic                   vsync_q, vsync_d;
  logic                   blank_q, blank_d;
  logic                   frame_start_q, frame_start_d;
  logic                   line_start_q, line_start_d;
  logic                   cfg_err_q, cfg_err_d;

  cfg_t                   cfg_in_s;
  logic                   cfg_in_ok_s;
  logic                   accept_s;
  logic                   load_s;
  logic                   run_s;
  logic                   h_last_s;
  logic                   v_last_s;
  logic                   frame_last_s;
  logic                   act_s;
  logic                   pattern_s;
  logic [2:0]             bar_s;

  // Gather the raw timing inputs into one candidate configuration.
  always_comb begin
    cfg_in_s.h_total = hsync_end_i;
    cfg_in_s.h_pulse = hpulse_end_i;
    cfg_in_s.h_dbeg  = hdata_begin_i;
    cfg_in_s.h_dend  = hdata_end_i;
    cfg_in_s.v_total = vsync_end_i;
    cfg_in_s.v_pulse = vpulse_end_i;
    cfg_in_s.v_dbeg  = vdata_begin_i;
    cfg_in_s.v_dend  = vdata_end_i;
    cfg_in_s.h_pol   = hsync_pol_i;
    cfg_in_s.v_pol   = vsync_pol_i;
  end

  // The cycle enable drops already behaves as idle, so outputs go inactive immediately.
  assign run_s        = (state_q == ST_RUN) && enable_i;
  assign h_last_s     = (hcnt_q == (cur_q.h_total - CNT_WIDTH'(1)));
  assign v_last_s     = (vcnt_q == (cur_q.v_total - CNT_WIDTH'(1)));
  assign frame_last_s = (state_q == ST_RUN) && h_last_s && v_last_s;
  assign act_s        = (hcnt_q >= cur_q.h_dbeg) && (hcnt_q < cur_q.h_dend) &&
                        (vcnt_q >= cur_q.v_dbeg) && (vcnt_q < cur_q.v_dend);
  assign cfg_in_ok_s  = cfg_ok(cfg_in_s);
  assign accept_s     = cfg_valid_i && cfg_in_ok_s;

`ifdef VGA_TIMING_TEST_PATTERN_EN
  assign pattern_s = self_test_i;
  assign bar_s     = 3'((hcnt_q - cur_q.h_dbeg) >> 3'd6);
`else
  logic unused_self_test_s;
  assign unused_self_test_s = self_test_i;
  assign pattern_s          = 1'b0;
  assign bar_s              = 3'd0;
`endif

  assign data_req_o = run_s && act_s && !pattern_s;
  assign hcnt_o     = hcnt_q;
  assign vcnt_o     = vcnt_q;

  // State and raster counters.
  always_comb begin
    state_d = ST_IDLE;
    hcnt_d  = '0;
    vcnt_d  = '0;
    case (state_q)
      ST_IDLE: state_d = enable_i ? ST_RUN : ST_IDLE;
      ST_RUN:  state_d = enable_i ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (run_s) begin
      if (h_last_s) begin
        hcnt_d = '0;
        vcnt_d = v_last_s ? '0 : (vcnt_q + CNT_WIDTH'(1));
      end else begin
        hcnt_d = hcnt_q + CNT_WIDTH'(1);
        vcnt_d = vcnt_q;
      end
    end else begin
      hcnt_d = '0;
      vcnt_d = '0;
    end
  end

  // Shadow configuration: a same-cycle accepted config beats an older pending one.
  always_comb begin
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    cfg_err_d  = cfg_valid_i && !cfg_in_ok_s;
    load_s     = ((state_q == ST_IDLE) && pend_vld_q) ||
                 (frame_last_s && (pend_vld_q || accept_s));
    if (accept_s) begin
      pend_d = cfg_in_s;
    end else begin
      pend_d = pend_q;
    end
    if (load_s) begin
      cur_d      = accept_s ? cfg_in_s : pend_q;
      pend_vld_d = 1'b0;
    end else if (accept_s) begin
      pend_vld_d = 1'b1;
    end else begin
      pend_vld_d = pend_vld_q;
    end
  end

  // Registered pixel, sync, blank and strobe outputs.
  always_comb begin
    hsync_d       = ~cur_q.h_pol;
    vsync_d       = ~cur_q.v_pol;
    blank_d       = 1'b0;
    red_d         = '0;
    green_d       = '0;
    blue_d        = '0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (run_s) begin
      hsync_d       = (hcnt_q < cur_q.h_pulse) ? cur_q.h_pol : ~cur_q.h_pol;
      vsync_d       = (vcnt_q < cur_q.v_pulse) ? cur_q.v_pol : ~cur_q.v_pol;
      line_start_d  = (hcnt_q == '0);
      frame_start_d = (hcnt_q == '0) && (vcnt_q == '0);
      blank_d       = act_s;
      if (act_s && pattern_s) begin
        red_d   = {COLOR_WIDTH{bar_s[0]}};
        green_d = {COLOR_WIDTH{bar_s[1]}};
        blue_d  = {COLOR_WIDTH{bar_s[2]}};
      end else if (act_s) begin
        red_d   = data_i[3*COLOR_WIDTH-1:2*COLOR_WIDTH];
        green_d = data_i[2*COLOR_WIDTH-1:COLOR_WIDTH];
        blue_d  = data_i[COLOR_WIDTH-1:0];
      end else begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
      end
    end else begin
      blank_d = 1'b0;
    end
  end

  // All state, including reset defaults for the shadow configuration.
  always_ff @(posedge clk_v) begin
    if (rst_v) begin
      state_q       <= ST_IDLE;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      cur_q         <= cfg_default();
      pend_q        <= cfg_default();
      pend_vld_q    <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      cur_q         <= cur_d;
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign red_o         = red_q;
  assign green_o       = green_q;
  assign blue_o        = blue_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign blank_o       = blank_q;
  assign frame_start_o = frame_start_q;
  assign line_start_o  = line_start_q;
  assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: frame-position model plus directed literal checks.
// Pattern checks are compiled in when VGA_TIMING_TEST_PATTERN_EN is defined.
module tb_vga_timing_gen;
  localparam int CW   = 12;
  localparam int COLW = 4;

  logic clk_v = 1'b0;
  logic rst_v, enable_i, cfg_valid_i, hsync_pol_i, vsync_pol_i, self_test_i;
  logic [CW-1:0] hsync_end_i, hpulse_end_i, hdata_begin_i, hdata_end_i;
  logic [CW-1:0] vsync_end_i, vpulse_end_i, vdata_begin_i, vdata_end_i;
  logic [3*COLW-1:0] data_i;
  logic data_req_o, hsync_o, vsync_o, blank_o, frame_start_o, line_start_o, cfg_err_o;
  logic [COLW-1:0] red_o, green_o, blue_o;
  logic [CW-1:0] hcnt_o, vcnt_o;

  int tests = 0;
  int fails = 0;

  vga_timing_gen #(.CNT_WIDTH(CW), .COLOR_WIDTH(COLW)) dut (
    .clk_v(clk_v), .rst_v(rst_v), .enable_i(enable_i), .cfg_valid_i(cfg_valid_i),
    .hsync_end_i(hsync_end_i), .hpulse_end_i(hpulse_end_i),
    .hdata_begin_i(hdata_begin_i), .hdata_end_i(hdata_end_i),
    .vsync_end_i(vsync_end_i), .vpulse_end_i(vpulse_end_i),
    .vdata_begin_i(vdata_begin_i), .vdata_end_i(vdata_end_i),
    .hsync_pol_i(hsync_pol_i), .vsync_pol_i(vsync_pol_i), .self_test_i(self_test_i),
    .data_i(data_i), .data_req_o(data_req_o), .red_o(red_o), .green_o(green_o),
    .blue_o(blue_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .blank_o(blank_o),
    .frame_start_o(frame_start_o), .line_start_o(line_start_o), .cfg_err_o(cfg_err_o),
    .hcnt_o(hcnt_o), .vcnt_o(vcnt_o)
  );

  always #5 clk_v = ~clk_v;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit cfg_good(input int h, input int hp, input int hb, input int he,
                                  input int v, input int vp, input int vb, input int ve);
    return (hp < hb) && (hb < he) && (he <= h) && (vp < vb) && (vb < ve) && (ve <= v);
  endfunction

  task automatic cyc();
    @(posedge clk_v);
    #1;
    data_i = data_i + 12'd1;
  endtask

  task automatic set_cfg(input int h, input int hp, input int hb, input int he,
                         input int v, input int vp, input int vb, input int ve,
                         input bit hpol, input bit vpol);
    hsync_end_i   = CW'(h);
    hpulse_end_i  = CW'(hp);
    hdata_begin_i = CW'(hb);
    hdata_end_i   = CW'(he);
    vsync_end_i   = CW'(v);
    vpulse_end_i  = CW'(vp);
    vdata_begin_i = CW'(vb);
    vdata_end_i   = CW'(ve);
    hsync_pol_i   = hpol;
    vsync_pol_i   = vpol;
  endtask

  // Model: config as {H,HP,HB,HE,V,VP,VB,VE,HPOL,VPOL}; raster position is a flat index in the frame.
  int m_cur[10];
  int m_pend[10];
  bit m_pend_v;
  bit m_run;
  int m_pos;
  int e_r, e_g, e_b;
  bit e_hs, e_vs, e_bl, e_fs, e_ls, e_err;

  always @(negedge clk_v) begin : model
    int h, v, bar;
    int in_cfg[10];
    bit act, live, pat, last, ok, hpol, vpol;
    in_cfg = '{int'(hsync_end_i), int'(hpulse_end_i), int'(hdata_begin_i), int'(hdata_end_i),
               int'(vsync_end_i), int'(vpulse_end_i), int'(vdata_begin_i), int'(vdata_end_i),
               int'(hsync_pol_i), int'(vsync_pol_i)};
    if (rst_v) begin
      m_cur = '{800, 96, 144, 784, 525, 2, 35, 515, 0, 0};
      m_pend_v = 1'b0; m_run = 1'b0; m_pos = 0;
      e_r = 0; e_g = 0; e_b = 0;
      e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_fs = 1'b0; e_ls = 1'b0; e_err = 1'b0;
    end else begin
      h = m_run ? (m_pos % m_cur[0]) : 0;
      v = m_run ? (m_pos / m_cur[0]) : 0;
      live = m_run && enable_i;
      act = (h >= m_cur[2]) && (h < m_cur[3]) && (v >= m_cur[6]) && (v < m_cur[7]);
`ifdef VGA_TIMING_TEST_PATTERN_EN
      pat = self_test_i;
`else
      pat = 1'b0;
`endif
      check("hcnt", hcnt_o, h);
      check("vcnt", vcnt_o, v);
      check("data_req", data_req_o, live && act && !pat);
      check("red", red_o, e_r);
      check("green", green_o, e_g);
      check("blue", blue_o, e_b);
      check("hsync", hsync_o, e_hs);
      check("vsync", vsync_o, e_vs);
      check("blank", blank_o, e_bl);
      check("frame_start", frame_start_o, e_fs);
      check("line_start", line_start_o, e_ls);
      check("cfg_err", cfg_err_o, e_err);

      hpol = (m_cur[8] != 0);
      vpol = (m_cur[9] != 0);
      e_hs = (live && (h < m_cur[1])) ? hpol : !hpol;
      e_vs = (live && (v < m_cur[5])) ? vpol : !vpol;
      e_bl = live && act;
      e_ls = live && (h == 0);
      e_fs = live && (h == 0) && (v == 0);
      if (e_bl && pat) begin
        bar = ((h - m_cur[2]) / 64) % 8;
        e_r = (bar % 2 == 1) ? 15 : 0;
        e_g = ((bar / 2) % 2 == 1) ? 15 : 0;
        e_b = (bar >= 4) ? 15 : 0;
      end else if (e_bl) begin
        e_r = int'(data_i[11:8]);
        e_g = int'(data_i[7:4]);
        e_b = int'(data_i[3:0]);
      end else begin
        e_r = 0; e_g = 0; e_b = 0;
      end

      ok = cfg_good(in_cfg[0], in_cfg[1], in_cfg[2], in_cfg[3],
                    in_cfg[4], in_cfg[5], in_cfg[6], in_cfg[7]);
      e_err = cfg_valid_i && !ok;
      last = m_run && (m_pos == m_cur[0] * m_cur[4] - 1);
      m_pos = (live && !last) ? m_pos + 1 : 0;
      if ((!m_run && m_pend_v) || (last && (m_pend_v || (cfg_valid_i && ok)))) begin
        if (cfg_valid_i && ok) m_cur = in_cfg;
        else m_cur = m_pend;
        m_pend_v = 1'b0;
      end else if (cfg_valid_i && ok) begin
        m_pend = in_cfg;
        m_pend_v = 1'b1;
      end
      m_run = enable_i;
    end
  end

  initial begin
    int k, hs_cnt, vs_cnt, dq_cnt, bl_cnt;
    rst_v = 1'b1; enable_i = 1'b0; cfg_valid_i = 1'b0; self_test_i = 1'b0; data_i = '0;
    set_cfg(800, 96, 144, 784, 525, 2, 35, 515, 1'b0, 1'b0);
    repeat (3) cyc();
    check("rst_hsync", hsync_o, 1);
    check("rst_vsync", vsync_o, 1);
    check("rst_blank", blank_o, 0);
    check("rst_red", red_o, 0);
    check("rst_data_req", data_req_o, 0);
    check("rst_hcnt", hcnt_o, 0);
    check("rst_cfg_err", cfg_err_o, 0);
    check("rst_frame_start", frame_start_o, 0);

    // Default 800x525 timing with data_i as a running counter.
    rst_v = 1'b0; enable_i = 1'b1;
    cyc();
    k = 0; hs_cnt = 0; vs_cnt = 0; dq_cnt = 0; bl_cnt = 0;
    while (k < 29100) begin
      if (k == 0) begin
        check("first_hcnt", hcnt_o, 0);
        check("first_vcnt", vcnt_o, 0);
        check("first_fs", frame_start_o, 0);
      end
      if (k == 1) begin
        check("fs_lag", frame_start_o, 1);
        check("ls_lag", line_start_o, 1);
      end
      if (k >= 1 && k <= 800 && hsync_o === 1'b0) hs_cnt++;
      if (vsync_o === 1'b0) vs_cnt++;
      if (k >= 28000 && k < 28800 && data_req_o === 1'b1) dq_cnt++;
      if (k >= 28001 && k <= 28800 && blank_o === 1'b1) bl_cnt++;
      cyc();
      k++;
    end
    check("hsync_low_line", hs_cnt, 96);
    check("vsync_low_frame", vs_cnt, 1600);
    check("data_req_line35", dq_cnt, 640);
    check("blank_line35", bl_cnt, 640);
    check("pre_drop_hcnt", hcnt_o, 300);
    check("pre_drop_vcnt", vcnt_o, 36);
    enable_i = 1'b0;
    cyc();
    check("drop_hcnt", hcnt_o, 0);
    check("drop_vcnt", vcnt_o, 0);
    check("drop_data_req", data_req_o, 0);
    check("drop_hsync", hsync_o, 1);

    // Rejected config: hdata_end beyond line total.
    set_cfg(800, 96, 144, 900, 525, 2, 35, 515, 1'b0, 1'b0);
    cfg_valid_i = 1'b1;
    cyc();
    cfg_valid_i = 1'b0;
    check("err_pulse", cfg_err_o, 1);
    cyc();
    check("err_clear", cfg_err_o, 0);

    // Small timing, then a mid-frame 1056-wide reconfig, then a frame-last reconfig.
    set_cfg(20, 3, 5, 15, 10, 2, 3, 8, 1'b0, 1'b0);
    cfg_valid_i = 1'b1;
    cyc();
    cfg_valid_i = 1'b0;
    check("small_no_err", cfg_err_o, 0);
    cyc();
    enable_i = 1'b1;
    cyc();
    k = 0; hs_cnt = 0;
    while (k < 6800) begin
      if (k == 20) begin
        check("small_wrap_h", hcnt_o, 0);
        check("small_wrap_v", vcnt_o, 1);
      end
      if (k == 250) begin
        set_cfg(1056, 128, 216, 1016, 6, 1, 2, 5, 1'b1, 1'b0);
        cfg_valid_i = 1'b1;
      end
      if (k == 251) cfg_valid_i = 1'b0;
      if (k == 399) begin
        check("old_frame_h", hcnt_o, 19);
        check("old_frame_v", vcnt_o, 9);
      end
      if (k >= 401 && k <= 1456 && hsync_o === 1'b1) hs_cnt++;
      if (k == 1455) begin
        check("wide_line_h", hcnt_o, 1055);
        check("wide_line_v", vcnt_o, 0);
      end
      if (k == 6735) begin
        check("wide_last_h", hcnt_o, 1055);
        check("wide_last_v", vcnt_o, 5);
        set_cfg(20, 3, 5, 15, 10, 2, 3, 8, 1'b0, 1'b0);
        cfg_valid_i = 1'b1;
      end
      if (k == 6736) begin
        cfg_valid_i = 1'b0;
        check("lastload_h", hcnt_o, 0);
        check("lastload_v", vcnt_o, 0);
      end
      if (k == 6756) begin
        check("lastload_wrap_h", hcnt_o, 0);
        check("lastload_wrap_v", vcnt_o, 1);
      end
      cyc();
      k++;
    end
    check("wide_hsync_high", hs_cnt, 128);
    enable_i = 1'b0;
    cyc();
    cyc();

    // Test pattern request (ignored when the feature is not built).
    set_cfg(700, 10, 20, 660, 4, 1, 2, 3, 1'b0, 1'b0);
    cfg_valid_i = 1'b1;
    cyc();
    cfg_valid_i = 1'b0;
    cyc();
    self_test_i = 1'b1;
    enable_i = 1'b1;
    cyc();
    k = 0; dq_cnt = 0;
    while (k < 2800) begin
      if (data_req_o === 1'b1) dq_cnt++;
      if (k == 1421) check("pat_blank", blank_o, 1);
`ifdef VGA_TIMING_TEST_PATTERN_EN
      if (k == 1421) begin
        check("bar0_r", red_o, 0); check("bar0_g", green_o, 0); check("bar0_b", blue_o, 0);
      end
      if (k == 1485) begin
        check("bar1_r", red_o, 15); check("bar1_g", green_o, 0); check("bar1_b", blue_o, 0);
      end
      if (k == 1549) begin
        check("bar2_r", red_o, 0); check("bar2_g", green_o, 15); check("bar2_b", blue_o, 0);
      end
      if (k == 1869) begin
        check("bar7_r", red_o, 15); check("bar7_g", green_o, 15); check("bar7_b", blue_o, 15);
      end
`endif
      cyc();
      k++;
    end
`ifdef VGA_TIMING_TEST_PATTERN_EN
    check("pat_data_req", dq_cnt, 0);
`else
    check("pat_data_req", dq_cnt, 640);
`endif
    enable_i = 1'b0;
    self_test_i = 1'b0;
    cyc();
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
